// File: rtl/decode_ctrl_pipe.sv
// RV32I decode into a registered ID/EX control bundle, 1-cycle latency; DECODE_PERF_EN adds stall/flush counters.
// Backpressure: ex_stall freezes ID/EX and drops id_ready; a load-use hazard inserts LOAD_LAT bubbles with id_ready low.
module decode_ctrl_pipe #(
  parameter int XLEN     = 32,
  parameter int ALUSEL_W = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_valid,
  input  logic [31:0]         if_instr,
  input  logic                flush,
  input  logic                ex_stall,
  output logic                id_ready,
  output logic                ex_valid,
  output logic                ex_regwrite,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [XLEN-1:0]     ex_imm,
  output logic [4:0]          ex_rs1,
  output logic [4:0]          ex_rs2,
  output logic [4:0]          ex_rd,
  output logic [2:0]          ex_funct3,
  output logic                ex_illegal,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
);

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                branch;
    logic                jump;
    logic                illegal;
    logic [ALUSEL_W-1:0] alusel;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [2:0]          funct3;
  } idex_t;

  typedef enum logic {S_RUN, S_STALL} state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [ALUSEL_W-1:0] ALU_ADD   = ALUSEL_W'(0);
  localparam logic [ALUSEL_W-1:0] ALU_SUB   = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] ALU_SLL   = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] ALU_SLT   = ALUSEL_W'(3);
  localparam logic [ALUSEL_W-1:0] ALU_SLTU  = ALUSEL_W'(4);
  localparam logic [ALUSEL_W-1:0] ALU_XOR   = ALUSEL_W'(5);
  localparam logic [ALUSEL_W-1:0] ALU_SRL   = ALUSEL_W'(6);
  localparam logic [ALUSEL_W-1:0] ALU_SRA   = ALUSEL_W'(7);
  localparam logic [ALUSEL_W-1:0] ALU_OR    = ALUSEL_W'(8);
  localparam logic [ALUSEL_W-1:0] ALU_AND   = ALUSEL_W'(9);
  localparam logic [ALUSEL_W-1:0] ALU_PASSB = ALUSEL_W'(10);
  localparam logic [2:0]          LAT       = 3'(LOAD_LAT);

  function automatic logic [ALUSEL_W-1:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_sel = ALU_SLL;
      3'd2:    alu_sel = ALU_SLT;
      3'd3:    alu_sel = ALU_SLTU;
      3'd4:    alu_sel = ALU_XOR;
      3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt, w_cnt_dec;
  idex_t       r_ex, w_dec;
  logic [31:0] w_imm32;
  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic        w_use_rs1, w_use_rs2, w_hazard, w_upd, w_take, w_id_ready;

  assign w_opcode  = if_instr[6:0];
  assign w_f3      = if_instr[14:12];
  assign w_f7      = if_instr[31:25];
  assign w_cnt_dec = r_cnt - 3'd1;

  always_comb begin
    w_dec        = '0;
    w_imm32      = '0;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    w_dec.valid  = 1'b1;
    w_dec.rs1    = if_instr[19:15];
    w_dec.rs2    = if_instr[24:20];
    w_dec.rd     = if_instr[11:7];
    w_dec.funct3 = w_f3;
    case (w_opcode)
      OP_R: begin
        if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))) begin
          w_dec.regwrite = 1'b1;
          w_dec.alusel   = alu_sel(w_f3, w_f7[5]);
          w_use_rs1      = 1'b1;
          w_use_rs2      = 1'b1;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        if ((w_f3 == 3'd1 && w_f7 != 7'h00) ||
            (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20)) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.regwrite = 1'b1;
          w_dec.alusel   = alu_sel(w_f3, (w_f3 == 3'd5) && w_f7[5]);
          w_use_rs1      = 1'b1;
          // shifts carry only the shamt; funct7 already chose SRL/SRA
          if (w_f3 == 3'd1 || w_f3 == 3'd5) w_imm32 = {27'd0, if_instr[24:20]};
          else                              w_imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        end
      end
      OP_LD: begin
        if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.memread  = 1'b1;
          w_dec.regwrite = 1'b1;
          w_use_rs1      = 1'b1;
          w_imm32        = {{20{if_instr[31]}}, if_instr[31:20]};
        end
      end
      OP_ST: begin
        if (w_f3 > 3'd2) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.memwrite = 1'b1;
          w_use_rs1      = 1'b1;
          w_use_rs2      = 1'b1;
          w_imm32        = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        end
      end
      OP_BR: begin
        if (w_f3 == 3'd2 || w_f3 == 3'd3) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.branch = 1'b1;
          w_use_rs1    = 1'b1;
          w_use_rs2    = 1'b1;
          w_imm32      = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
        end
      end
      OP_JAL: begin
        w_dec.jump     = 1'b1;
        w_dec.regwrite = 1'b1;
        w_imm32        = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                          if_instr[20], if_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        if (w_f3 != 3'd0) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.jump     = 1'b1;
          w_dec.regwrite = 1'b1;
          w_use_rs1      = 1'b1;
          w_imm32        = {{20{if_instr[31]}}, if_instr[31:20]};
        end
      end
      OP_LUI: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusel   = ALU_PASSB;
        w_imm32        = {if_instr[31:12], 12'd0};
      end
      OP_AUIPC: begin
        w_dec.regwrite = 1'b1;
        w_imm32        = {if_instr[31:12], 12'd0};
      end
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.imm = XLEN'($signed(w_imm32));
    if (w_dec.rd == 5'd0) w_dec.regwrite = 1'b0;
  end

  assign w_hazard = r_ex.valid && r_ex.memread && (r_ex.rd != 5'd0) && if_valid &&
                    ((w_use_rs1 && w_dec.rs1 == r_ex.rd) || (w_use_rs2 && w_dec.rs2 == r_ex.rd));

  // The hazard cycle is the first bubble; the counter leaves STALL once it reaches 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_id_ready  = 1'b1;
    w_upd       = 1'b1;
    w_take      = 1'b0;
    if (flush) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = 3'd0;
    end else if (ex_stall) begin
      w_id_ready = 1'b0;
      w_upd      = 1'b0;
    end else if (r_state == S_STALL) begin
      w_id_ready  = 1'b0;
      w_state_nxt = (w_cnt_dec == 3'd1) ? S_RUN : S_STALL;
      w_cnt_nxt   = (w_cnt_dec == 3'd1) ? 3'd0 : w_cnt_dec;
    end else if (w_hazard) begin
      w_id_ready  = 1'b0;
      w_state_nxt = (LAT == 3'd1) ? S_RUN : S_STALL;
      w_cnt_nxt   = (LAT == 3'd1) ? 3'd0 : LAT;
    end else begin
      w_take = if_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ex <= '0;
    else if (w_upd) r_ex <= w_take ? w_dec : '0;
  end

  assign id_ready    = w_id_ready;
  assign ex_valid    = r_ex.valid;
  assign ex_regwrite = r_ex.regwrite;
  assign ex_memread  = r_ex.memread;
  assign ex_memwrite = r_ex.memwrite;
  assign ex_branch   = r_ex.branch;
  assign ex_jump     = r_ex.jump;
  assign ex_alusel   = r_ex.alusel;
  assign ex_imm      = r_ex.imm;
  assign ex_rs1      = r_ex.rs1;
  assign ex_rs2      = r_ex.rs2;
  assign ex_rd       = r_ex.rd;
  assign ex_funct3   = r_ex.funct3;
  assign ex_illegal  = r_ex.illegal;

`ifdef DECODE_PERF_EN
  logic [31:0] r_perf_stall, r_perf_flush;
  logic        w_haz_bubble;

  assign w_haz_bubble = !flush && !ex_stall && (r_state == S_STALL || w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (w_haz_bubble && r_perf_stall != 32'hFFFF_FFFF) r_perf_stall <= r_perf_stall + 32'd1;
      if (flush && r_perf_flush != 32'hFFFF_FFFF)        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: two instances (LOAD_LAT=1 and 3) share one stimulus stream.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, flush, ex_stall;
  logic [31:0] if_instr;
  int          errors = 0;
  int          checks = 0;

  logic        a_id_ready, a_ex_valid, a_ex_regwrite, a_ex_memread, a_ex_memwrite;
  logic        a_ex_branch, a_ex_jump, a_ex_illegal;
  logic [3:0]  a_ex_alusel;
  logic [31:0] a_ex_imm, a_perf_stall, a_perf_flush;
  logic [4:0]  a_ex_rs1, a_ex_rs2, a_ex_rd;
  logic [2:0]  a_ex_funct3;

  logic        b_id_ready, b_ex_valid, b_ex_regwrite, b_ex_memread, b_ex_memwrite;
  logic        b_ex_branch, b_ex_jump, b_ex_illegal;
  logic [3:0]  b_ex_alusel;
  logic [31:0] b_ex_imm, b_perf_stall, b_perf_flush;
  logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;
  logic [2:0]  b_ex_funct3;

  localparam logic [31:0] I_ADDI = 32'hFFF0_0293;  // addi x5,x0,-1
  localparam logic [31:0] I_LW   = 32'h0000_A303;  // lw x6,0(x1)
  localparam logic [31:0] I_ADD  = 32'h0023_03B3;  // add x7,x6,x2
  localparam logic [31:0] I_LUI  = 32'h1234_5337;  // lui x6,0x12345
  localparam logic [31:0] I_BEQ  = 32'hFE20_8EE3;  // beq x1,x2,-4
  localparam logic [31:0] I_SW   = 32'hFE20_AC23;  // sw x2,-8(x1)
  localparam logic [31:0] I_JAL  = 32'h0080_00EF;  // jal x1,8
  localparam logic [31:0] I_NOP1 = 32'h0010_0013;  // addi x0,x0,1
  localparam logic [31:0] I_SUB  = 32'h4020_81B3;  // sub x3,x1,x2
  localparam logic [31:0] I_SRAI = 32'h4040_D193;  // srai x3,x1,4
  localparam logic [31:0] I_MUL  = 32'h0220_81B3;  // funct7=1 on OP: illegal here
  localparam logic [31:0] I_BAD  = 32'h0000_007F;

  decode_ctrl_pipe #(.XLEN(32), .ALUSEL_W(4), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .flush(flush), .ex_stall(ex_stall), .id_ready(a_id_ready),
    .ex_valid(a_ex_valid), .ex_regwrite(a_ex_regwrite), .ex_memread(a_ex_memread),
    .ex_memwrite(a_ex_memwrite), .ex_branch(a_ex_branch), .ex_jump(a_ex_jump),
    .ex_alusel(a_ex_alusel), .ex_imm(a_ex_imm), .ex_rs1(a_ex_rs1), .ex_rs2(a_ex_rs2),
    .ex_rd(a_ex_rd), .ex_funct3(a_ex_funct3), .ex_illegal(a_ex_illegal),
    .perf_stall_cnt(a_perf_stall), .perf_flush_cnt(a_perf_flush)
  );

  decode_ctrl_pipe #(.XLEN(32), .ALUSEL_W(4), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .flush(flush), .ex_stall(ex_stall), .id_ready(b_id_ready),
    .ex_valid(b_ex_valid), .ex_regwrite(b_ex_regwrite), .ex_memread(b_ex_memread),
    .ex_memwrite(b_ex_memwrite), .ex_branch(b_ex_branch), .ex_jump(b_ex_jump),
    .ex_alusel(b_ex_alusel), .ex_imm(b_ex_imm), .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2),
    .ex_rd(b_ex_rd), .ex_funct3(b_ex_funct3), .ex_illegal(b_ex_illegal),
    .perf_stall_cnt(b_perf_stall), .perf_flush_cnt(b_perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] ins);
    if_valid = v;
    if_instr = ins;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    drv(1'b0, 32'd0);
    flush    = 1'b0;
    ex_stall = 1'b0;
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; flush = 1'b0; ex_stall = 1'b0;
    #3;
    chk("rst_valid", a_ex_valid, 1'b0);
    chk("rst_regwrite", a_ex_regwrite, 1'b0);
    chk("rst_imm", a_ex_imm, 32'd0);
    chk("rst_illegal", a_ex_illegal, 1'b0);
    chk("rst_ready1", a_id_ready, 1'b1);
    chk("rst_ready3", b_id_ready, 1'b1);
    #9 rst_n = 1'b1;
    tick();

    // addi x5,x0,-1
    drv(1'b1, I_ADDI);
    #1 chk("addi_rdy", a_id_ready, 1'b1);
    tick();
    chk("addi_valid", a_ex_valid, 1'b1);
    chk("addi_imm", a_ex_imm, 32'hFFFF_FFFF);
    chk("addi_alusel", a_ex_alusel, 4'd0);
    chk("addi_regwrite", a_ex_regwrite, 1'b1);
    chk("addi_rd", a_ex_rd, 5'd5);

    // load-use: lw x6 then add x7,x6,x2
    drv(1'b1, I_LW);
    tick();
    chk("lw_memread", a_ex_memread, 1'b1);
    chk("lw_rd", a_ex_rd, 5'd6);
    drv(1'b1, I_ADD);
    #1 chk("haz_rdy_l1", a_id_ready, 1'b0);
    chk("haz_rdy_l3", b_id_ready, 1'b0);
    tick();
    chk("l1_bubble", a_ex_valid, 1'b0);
    chk("l3_bubble1", b_ex_valid, 1'b0);
    #1 chk("l1_rdy_after", a_id_ready, 1'b1);
    chk("l3_rdy_stall1", b_id_ready, 1'b0);
    tick();
    chk("l1_add_valid", a_ex_valid, 1'b1);
    chk("l1_add_rd", a_ex_rd, 5'd7);
    chk("l1_add_regwrite", a_ex_regwrite, 1'b1);
    chk("l3_bubble2", b_ex_valid, 1'b0);
    #1 chk("l3_rdy_stall2", b_id_ready, 1'b0);
    tick();
    chk("l3_bubble3", b_ex_valid, 1'b0);
    #1 chk("l3_rdy_run", b_id_ready, 1'b1);
    tick();
    chk("l3_add_valid", b_ex_valid, 1'b1);
    chk("l3_add_rd", b_ex_rd, 5'd7);

    // if_valid low loads a bubble
    drv(1'b0, I_ADD);
    #1 chk("idle_rdy", a_id_ready, 1'b1);
    tick();
    chk("idle_bubble", a_ex_valid, 1'b0);

    // lw x6 then lui x6: no hazard
    do_reset();
    drv(1'b1, I_LW);
    tick();
    drv(1'b1, I_LUI);
    #1 chk("lui_rdy_l1", a_id_ready, 1'b1);
    chk("lui_rdy_l3", b_id_ready, 1'b1);
    tick();
    chk("lui_valid", b_ex_valid, 1'b1);
    chk("lui_imm", b_ex_imm, 32'h1234_5000);
    chk("lui_alusel", b_ex_alusel, 4'd10);
    chk("lui_regwrite", a_ex_regwrite, 1'b1);

    // flush in the second STALL cycle at LOAD_LAT=3
    do_reset();
    drv(1'b1, I_LW);
    tick();
    drv(1'b1, I_ADD);
    tick();
    tick();
    flush = 1'b1;
    #1 chk("fl_rdy", b_id_ready, 1'b1);
    tick();
    flush = 1'b0;
    chk("fl_bubble", b_ex_valid, 1'b0);
    #1 chk("fl_run_rdy", b_id_ready, 1'b1);
    tick();
    chk("fl_add_valid", b_ex_valid, 1'b1);
`ifdef DECODE_PERF_EN
    chk("perf_stall_l3", b_perf_stall, 32'd2);
    chk("perf_flush_l3", b_perf_flush, 32'd1);
    chk("perf_stall_l1", a_perf_stall, 32'd1);
`else
    chk("perf_stall_tied", b_perf_stall, 32'd0);
    chk("perf_flush_tied", b_perf_flush, 32'd0);
`endif

    // beq then ex_stall for 4 cycles
    do_reset();
    drv(1'b1, I_BEQ);
    tick();
    chk("beq_branch", a_ex_branch, 1'b1);
    chk("beq_imm", a_ex_imm, 32'hFFFF_FFFC);
    chk("beq_regwrite", a_ex_regwrite, 1'b0);
    ex_stall = 1'b1;
    drv(1'b1, I_ADDI);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("hold_rdy%0d", i), a_id_ready, 1'b0);
      tick();
      chk($sformatf("hold_branch%0d", i), a_ex_branch, 1'b1);
      chk($sformatf("hold_imm%0d", i), a_ex_imm, 32'hFFFF_FFFC);
    end
    flush = 1'b1;
    #1 chk("flush_over_hold_rdy", a_id_ready, 1'b1);
    tick();
    flush = 1'b0;
    ex_stall = 1'b0;
    chk("flush_over_hold_bubble", a_ex_valid, 1'b0);

    // assorted formats
    drv(1'b1, I_SW);
    tick();
    chk("sw_memwrite", a_ex_memwrite, 1'b1);
    chk("sw_imm", a_ex_imm, 32'hFFFF_FFF8);
    chk("sw_regwrite", a_ex_regwrite, 1'b0);
    drv(1'b1, I_JAL);
    tick();
    chk("jal_jump", a_ex_jump, 1'b1);
    chk("jal_imm", a_ex_imm, 32'd8);
    chk("jal_regwrite", a_ex_regwrite, 1'b1);
    drv(1'b1, I_NOP1);
    tick();
    chk("x0_valid", a_ex_valid, 1'b1);
    chk("x0_regwrite", a_ex_regwrite, 1'b0);
    chk("x0_imm", a_ex_imm, 32'd1);
    drv(1'b1, I_SUB);
    tick();
    chk("sub_alusel", a_ex_alusel, 4'd1);
    drv(1'b1, I_SRAI);
    tick();
    chk("srai_alusel", a_ex_alusel, 4'd7);
    chk("srai_imm", a_ex_imm, 32'd4);
    drv(1'b1, I_MUL);
    tick();
    chk("badf7_illegal", a_ex_illegal, 1'b1);
    chk("badf7_regwrite", a_ex_regwrite, 1'b0);

    // illegal opcode, then asynchronous reset mid-cycle
    drv(1'b1, I_BAD);
    tick();
    chk("ill_flag", a_ex_illegal, 1'b1);
    chk("ill_regwrite", a_ex_regwrite, 1'b0);
    chk("ill_valid", a_ex_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1 chk("arst_valid", a_ex_valid, 1'b0);
    chk("arst_illegal", a_ex_illegal, 1'b0);
    chk("arst_rdy", a_id_ready, 1'b1);
    chk("arst_perf_stall", b_perf_stall, 32'd0);
    chk("arst_perf_flush", b_perf_flush, 32'd0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
